// File: rtl/disc_sprite_pkg.sv
// disc_sprite_pkg: shared constants, types and helpers for the disc sprite
// pipeline (disc_sprite_pipe and its parameter double-buffer).

package disc_sprite_pkg;

   // Cycles from hcount/vcount/pixel_valid sampling to the registered outputs.
   localparam int LATENCY = 3;

   // One RGB888 pixel, most significant byte first: {R,G,B}.
   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb888_t;

   // Width needed to hold the square of an unsigned w-bit value.
   function automatic int sq_w(input int w);
      return 2 * w;
   endfunction

endpackage

// File: rtl/sprite_param_dbuf.sv
// sprite_param_dbuf: shadow/active parameter registers for the disc sprite.
// update_i captures a shadow set and marks it pending; new_frame_i promotes
// the pending set (or the live inputs, when both pulses coincide) into the
// active set and precomputes radius squared so the datapath never sees a
// mid-frame change.
// Optional feature macro: DISC_SPRITE_OUTLINE_EN (adds the inner-ring square).

module sprite_param_dbuf
   import disc_sprite_pkg::*;
#(
   parameter int H_W    = 11,
   parameter int V_W    = 10,
`ifdef DISC_SPRITE_OUTLINE_EN
   parameter int RING_W = 4,
`endif
   parameter int R_W    = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   new_frame_i,
   input  logic                   update_i,
   input  logic [H_W-1:0]         x_i,
   input  logic [V_W-1:0]         y_i,
   input  logic [R_W-1:0]         radius_i,
   output logic [H_W-1:0]         act_x_o,
   output logic [V_W-1:0]         act_y_o,
`ifdef DISC_SPRITE_OUTLINE_EN
   output logic [sq_w(R_W)-1:0]   act_inner_sq_o,
   output logic                   act_ring_en_o,
`endif
   output logic [sq_w(R_W)-1:0]   act_r_sq_o
);

   localparam int RSQ_W = sq_w(R_W);

   logic [H_W-1:0]   sh_x_q, sh_x_d;
   logic [V_W-1:0]   sh_y_q, sh_y_d;
   logic [R_W-1:0]   sh_r_q, sh_r_d;
   logic             pending_q, pending_d;
   logic [H_W-1:0]   act_x_q, act_x_d;
   logic [V_W-1:0]   act_y_q, act_y_d;
   logic [RSQ_W-1:0] act_r_sq_q, act_r_sq_d;

   logic             load_s;
   logic [H_W-1:0]   src_x_s;
   logic [V_W-1:0]   src_y_s;
   logic [R_W-1:0]   src_r_s;
   logic [RSQ_W-1:0] src_r_sq_s;

`ifdef DISC_SPRITE_OUTLINE_EN
   logic [R_W-1:0]   inner_r_s;
   logic [RSQ_W-1:0] inner_sq_s;
   logic             ring_en_s;
   logic [RSQ_W-1:0] act_inner_sq_q, act_inner_sq_d;
   logic             act_ring_en_q, act_ring_en_d;
`endif

   // Load source: live inputs win over the shadow when update and frame start coincide.
   always_comb begin
      load_s = new_frame_i & (update_i | pending_q);
      if (update_i) begin
         src_x_s = x_i;
         src_y_s = y_i;
         src_r_s = radius_i;
      end else begin
         src_x_s = sh_x_q;
         src_y_s = sh_y_q;
         src_r_s = sh_r_q;
      end
      src_r_sq_s = RSQ_W'(src_r_s) * RSQ_W'(src_r_s);
   end

`ifdef DISC_SPRITE_OUTLINE_EN
   // Inner ring threshold; radii not larger than the ring width stay filled discs.
   always_comb begin
      inner_r_s = src_r_s - R_W'(RING_W);
      if (src_r_s > R_W'(RING_W)) begin
         ring_en_s  = 1'b1;
         inner_sq_s = RSQ_W'(inner_r_s) * RSQ_W'(inner_r_s);
      end else begin
         ring_en_s  = 1'b0;
         inner_sq_s = {RSQ_W{1'b0}};
      end
   end
`endif

   // Next-state for shadow set, pending flag and active set.
   always_comb begin
      if (update_i) begin
         sh_x_d = x_i;
         sh_y_d = y_i;
         sh_r_d = radius_i;
      end else begin
         sh_x_d = sh_x_q;
         sh_y_d = sh_y_q;
         sh_r_d = sh_r_q;
      end

      if (new_frame_i) begin
         pending_d = 1'b0;
      end else if (update_i) begin
         pending_d = 1'b1;
      end else begin
         pending_d = pending_q;
      end

      if (load_s) begin
         act_x_d    = src_x_s;
         act_y_d    = src_y_s;
         act_r_sq_d = src_r_sq_s;
      end else begin
         act_x_d    = act_x_q;
         act_y_d    = act_y_q;
         act_r_sq_d = act_r_sq_q;
      end
`ifdef DISC_SPRITE_OUTLINE_EN
      if (load_s) begin
         act_inner_sq_d = inner_sq_s;
         act_ring_en_d  = ring_en_s;
      end else begin
         act_inner_sq_d = act_inner_sq_q;
         act_ring_en_d  = act_ring_en_q;
      end
`endif
   end

   // Parameter state registers, cleared asynchronously to a radius-0 sprite at (0,0).
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sh_x_q     <= {H_W{1'b0}};
         sh_y_q     <= {V_W{1'b0}};
         sh_r_q     <= {R_W{1'b0}};
         pending_q  <= 1'b0;
         act_x_q    <= {H_W{1'b0}};
         act_y_q    <= {V_W{1'b0}};
         act_r_sq_q <= {RSQ_W{1'b0}};
      end else begin
         sh_x_q     <= sh_x_d;
         sh_y_q     <= sh_y_d;
         sh_r_q     <= sh_r_d;
         pending_q  <= pending_d;
         act_x_q    <= act_x_d;
         act_y_q    <= act_y_d;
         act_r_sq_q <= act_r_sq_d;
      end
   end

`ifdef DISC_SPRITE_OUTLINE_EN
   // Active ring threshold registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         act_inner_sq_q <= {RSQ_W{1'b0}};
         act_ring_en_q  <= 1'b0;
      end else begin
         act_inner_sq_q <= act_inner_sq_d;
         act_ring_en_q  <= act_ring_en_d;
      end
   end

   assign act_inner_sq_o = act_inner_sq_q;
   assign act_ring_en_o  = act_ring_en_q;
`endif

   assign act_x_o    = act_x_q;
   assign act_y_o    = act_y_q;
   assign act_r_sq_o = act_r_sq_q;

endmodule

// File: rtl/disc_sprite_pipe.sv
// disc_sprite_pipe: three-stage pipelined disc (or ring) sprite.
// S1 absolute offsets, S2 squares, S3 distance compare; colour is decoded
// from the registered hit. Each pixel carries its radius thresholds down the
// pipe so a frame-boundary parameter swap never splits a pixel across sets.
// Optional feature macro: DISC_SPRITE_OUTLINE_EN (outline ring of RING_W px).

module disc_sprite_pipe
   import disc_sprite_pkg::*;
#(
   parameter int          H_W    = 11,
   parameter int          V_W    = 10,
   parameter int          R_W    = 8,
   parameter logic [23:0] COLOR  = 24'hFF_FF_FF,
   parameter int          RING_W = 4
) (
   input  logic           clk_in,
   input  logic           rst_n_in,
   input  logic [H_W-1:0] hcount_in,
   input  logic [V_W-1:0] vcount_in,
   input  logic           pixel_valid_in,
   input  logic           new_frame_in,
   input  logic [H_W-1:0] x_in,
   input  logic [V_W-1:0] y_in,
   input  logic [R_W-1:0] radius_in,
   input  logic           update_in,
   output logic [7:0]     red_out,
   output logic [7:0]     green_out,
   output logic [7:0]     blue_out,
   output logic           hit_out,
   output logic           pixel_valid_out
);

   localparam int DX2_W = sq_w(H_W);
   localparam int DY2_W = sq_w(V_W);
   localparam int D2_W  = DX2_W + 1;
   localparam int RSQ_W = sq_w(R_W);

   logic [H_W-1:0]   act_x_s;
   logic [V_W-1:0]   act_y_s;
   logic [RSQ_W-1:0] act_r_sq_s;

   logic [H_W-1:0]   dx_q, dx_d;
   logic [V_W-1:0]   dy_q, dy_d;
   logic             v1_q;
   logic [RSQ_W-1:0] rsq1_q;

   logic [DX2_W-1:0] dx2_q, dx2_d;
   logic [DY2_W-1:0] dy2_q, dy2_d;
   logic             v2_q;
   logic [RSQ_W-1:0] rsq2_q;

   logic [D2_W-1:0]  d2_s;
   logic             in_outer_s;
   logic             hit_q, hit_d;
   logic             pv_q;
   rgb888_t          color_s;

`ifdef DISC_SPRITE_OUTLINE_EN
   logic [RSQ_W-1:0] act_inner_sq_s;
   logic             act_ring_en_s;
   logic [RSQ_W-1:0] inner1_q, inner2_q;
   logic             ring1_q, ring2_q;
   logic             in_inner_s;
`endif

   sprite_param_dbuf #(
      .H_W           (H_W),
      .V_W           (V_W),
`ifdef DISC_SPRITE_OUTLINE_EN
      .RING_W        (RING_W),
`endif
      .R_W           (R_W)
   ) u_dbuf (
      .clk_i         (clk_in),
      .rst_n_i       (rst_n_in),
      .new_frame_i   (new_frame_in),
      .update_i      (update_in),
      .x_i           (x_in),
      .y_i           (y_in),
      .radius_i      (radius_in),
      .act_x_o       (act_x_s),
      .act_y_o       (act_y_s),
`ifdef DISC_SPRITE_OUTLINE_EN
      .act_inner_sq_o(act_inner_sq_s),
      .act_ring_en_o (act_ring_en_s),
`endif
      .act_r_sq_o    (act_r_sq_s)
   );

   // S1 comb: unsigned distance from the centre, compare first so nothing wraps.
   always_comb begin
      if (hcount_in >= act_x_s) begin
         dx_d = hcount_in - act_x_s;
      end else begin
         dx_d = act_x_s - hcount_in;
      end
      if (vcount_in >= act_y_s) begin
         dy_d = vcount_in - act_y_s;
      end else begin
         dy_d = act_y_s - vcount_in;
      end
   end

   // S2 comb: full-width squares of the offsets.
   always_comb begin
      dx2_d = DX2_W'(dx_q) * DX2_W'(dx_q);
      dy2_d = DY2_W'(dy_q) * DY2_W'(dy_q);
   end

   // S3 comb: squared distance against the thresholds that travelled with the pixel.
   always_comb begin
      d2_s       = D2_W'(dx2_q) + D2_W'(dy2_q);
      in_outer_s = (d2_s <= D2_W'(rsq2_q));
`ifdef DISC_SPRITE_OUTLINE_EN
      if (ring2_q) begin
         in_inner_s = (d2_s <= D2_W'(inner2_q));
      end else begin
         in_inner_s = 1'b0;
      end
      hit_d = v2_q & in_outer_s & ~in_inner_s;
`else
      hit_d = v2_q & in_outer_s;
`endif
   end

   // Pipeline registers S1..S3; reset empties the pipe and drops all hits at once.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         dx_q   <= {H_W{1'b0}};
         dy_q   <= {V_W{1'b0}};
         v1_q   <= 1'b0;
         rsq1_q <= {RSQ_W{1'b0}};
         dx2_q  <= {DX2_W{1'b0}};
         dy2_q  <= {DY2_W{1'b0}};
         v2_q   <= 1'b0;
         rsq2_q <= {RSQ_W{1'b0}};
         hit_q  <= 1'b0;
         pv_q   <= 1'b0;
      end else begin
         dx_q   <= dx_d;
         dy_q   <= dy_d;
         v1_q   <= pixel_valid_in;
         rsq1_q <= act_r_sq_s;
         dx2_q  <= dx2_d;
         dy2_q  <= dy2_d;
         v2_q   <= v1_q;
         rsq2_q <= rsq1_q;
         hit_q  <= hit_d;
         pv_q   <= v2_q;
      end
   end

`ifdef DISC_SPRITE_OUTLINE_EN
   // Ring thresholds ride alongside the pixel through S1 and S2.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         inner1_q <= {RSQ_W{1'b0}};
         ring1_q  <= 1'b0;
         inner2_q <= {RSQ_W{1'b0}};
         ring2_q  <= 1'b0;
      end else begin
         inner1_q <= act_inner_sq_s;
         ring1_q  <= act_ring_en_s;
         inner2_q <= inner1_q;
         ring2_q  <= ring1_q;
      end
   end
`endif

   // Colour decode from the registered hit: sprite colour or black.
   always_comb begin
      if (hit_q) begin
         color_s = COLOR;
      end else begin
         color_s = 24'h00_00_00;
      end
   end

   assign red_out         = color_s.r;
   assign green_out       = color_s.g;
   assign blue_out        = color_s.b;
   assign hit_out         = hit_q;
   assign pixel_valid_out = pv_q;

endmodule

// File: tb/tb_disc_sprite_pipe.sv
// tb_disc_sprite_pipe: directed plus randomized bench for disc_sprite_pipe.
// Expected outputs come from a distance-squared model of the sprite rules,
// delayed by the pipeline latency. Honours DISC_SPRITE_OUTLINE_EN when defined.

module tb_disc_sprite_pipe;
   import disc_sprite_pkg::*;

   localparam int          H_W     = 11;
   localparam int          V_W     = 10;
   localparam int          R_W     = 8;
   localparam int          RING_W  = 4;
   localparam logic [23:0] COLOR_C = 24'hC0_5A_17;

   logic           clk_in = 1'b0;
   logic           rst_n_in;
   logic [H_W-1:0] hcount_in;
   logic [V_W-1:0] vcount_in;
   logic           pixel_valid_in;
   logic           new_frame_in;
   logic [H_W-1:0] x_in;
   logic [V_W-1:0] y_in;
   logic [R_W-1:0] radius_in;
   logic           update_in;
   logic [7:0]     red_out, green_out, blue_out;
   logic           hit_out, pixel_valid_out;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: parameter sets and the expected output delay line.
   int m_ax, m_ay, m_ar, m_sx, m_sy, m_sr;
   bit m_pend;
   bit eh [LATENCY];
   bit ev [LATENCY];

   disc_sprite_pipe #(
      .H_W(H_W), .V_W(V_W), .R_W(R_W), .COLOR(COLOR_C), .RING_W(RING_W)
   ) dut (
      .clk_in         (clk_in),
      .rst_n_in       (rst_n_in),
      .hcount_in      (hcount_in),
      .vcount_in      (vcount_in),
      .pixel_valid_in (pixel_valid_in),
      .new_frame_in   (new_frame_in),
      .x_in           (x_in),
      .y_in           (y_in),
      .radius_in      (radius_in),
      .update_in      (update_in),
      .red_out        (red_out),
      .green_out      (green_out),
      .blue_out       (blue_out),
      .hit_out        (hit_out),
      .pixel_valid_out(pixel_valid_out)
   );

   // Pixel clock.
   always #5 clk_in = ~clk_in;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit model_hit(input int h, input int v, input bit valid);
      int dx, dy, d2, ir;
      bit hit;
      dx  = (h > m_ax) ? h - m_ax : m_ax - h;
      dy  = (v > m_ay) ? v - m_ay : m_ay - v;
      d2  = dx * dx + dy * dy;
      hit = valid && (d2 <= m_ar * m_ar);
`ifdef DISC_SPRITE_OUTLINE_EN
      if (m_ar > RING_W) begin
         ir = m_ar - RING_W;
         if (d2 <= ir * ir) hit = 1'b0;
      end
`else
      ir = 0;
`endif
      return hit;
   endfunction

   task automatic model_clear();
      m_ax = 0; m_ay = 0; m_ar = 0;
      m_sx = 0; m_sy = 0; m_sr = 0;
      m_pend = 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
         eh[i] = 1'b0;
         ev[i] = 1'b0;
      end
   endtask

   task automatic check_outputs(input string tag);
      bit e;
      e = eh[LATENCY-1];
      check_val({tag, "_hit"}, int'(hit_out), int'(e));
      check_val({tag, "_pv"}, int'(pixel_valid_out), int'(ev[LATENCY-1]));
      check_val({tag, "_r"}, int'(red_out),   e ? int'(COLOR_C[23:16]) : 0);
      check_val({tag, "_g"}, int'(green_out), e ? int'(COLOR_C[15:8])  : 0);
      check_val({tag, "_b"}, int'(blue_out),  e ? int'(COLOR_C[7:0])   : 0);
   endtask

   // One clock: model sees the same sampled inputs as the DUT, then outputs are checked.
   task automatic tick(input string tag);
      @(posedge clk_in);
      if (!rst_n_in) begin
         model_clear();
      end else begin
         for (int i = LATENCY - 1; i > 0; i--) begin
            eh[i] = eh[i-1];
            ev[i] = ev[i-1];
         end
         eh[0] = model_hit(int'(hcount_in), int'(vcount_in), pixel_valid_in);
         ev[0] = pixel_valid_in;
         if (new_frame_in && update_in) begin
            m_ax = int'(x_in); m_ay = int'(y_in); m_ar = int'(radius_in);
            m_sx = m_ax; m_sy = m_ay; m_sr = m_ar;
            m_pend = 1'b0;
         end else if (new_frame_in && m_pend) begin
            m_ax = m_sx; m_ay = m_sy; m_ar = m_sr;
            m_pend = 1'b0;
         end else if (update_in) begin
            m_sx = int'(x_in); m_sy = int'(y_in); m_sr = int'(radius_in);
            m_pend = 1'b1;
         end
      end
      #1;
      check_outputs(tag);
      update_in    = 1'b0;
      new_frame_in = 1'b0;
   endtask

   task automatic set_params(input int x, input int y, input int r, input bit up, input bit nf);
      x_in = H_W'(x); y_in = V_W'(y); radius_in = R_W'(r);
      update_in = up; new_frame_in = nf;
      pixel_valid_in = 1'b0;
      tick("param");
   endtask

   // Drive one pixel, flush the pipe and compare against a hand-derived expectation.
   task automatic probe(input string tag, input int h, input int v, input bit valid, input bit exp_hit);
      hcount_in = H_W'(h); vcount_in = V_W'(v); pixel_valid_in = valid;
      tick(tag);
      pixel_valid_in = 1'b0;
      for (int i = 1; i < LATENCY; i++) tick(tag);
      check_val({tag, "_fixed_hit"}, int'(hit_out), int'(exp_hit));
      check_val({tag, "_fixed_red"}, int'(red_out), exp_hit ? int'(COLOR_C[23:16]) : 0);
   endtask

   bit exp_b;

   initial begin
      rst_n_in = 1'b0;
      hcount_in = '0; vcount_in = '0; pixel_valid_in = 1'b0;
      new_frame_in = 1'b0; update_in = 1'b0;
      x_in = '0; y_in = '0; radius_in = '0;
      model_clear();
      tick("reset");
      tick("reset");
      rst_n_in = 1'b1;

      // Centre (320,240), r=64 via shadow then frame start.
      set_params(320, 240, 64, 1'b1, 1'b0);
      check_val("pending_after_update", int'(dut.u_dbuf.pending_q), 1);
      set_params(0, 0, 0, 1'b0, 1'b1);
      check_val("pending_after_frame", int'(dut.u_dbuf.pending_q), 0);
      probe("edge_384", 384, 240, 1'b1, 1'b1);
      probe("out_385", 385, 240, 1'b1, 1'b0);
      probe("diag_365", 365, 285, 1'b1, 1'b1);
`ifdef DISC_SPRITE_OUTLINE_EN
      probe("ring_382", 382, 240, 1'b1, 1'b1);
      probe("ring_379", 379, 240, 1'b1, 1'b0);
      exp_b = 1'b0;
`else
      probe("disc_379", 379, 240, 1'b1, 1'b1);
      exp_b = 1'b1;
`endif
      probe("centre", 320, 240, 1'b1, exp_b);
      probe("centre_novalid", 320, 240, 1'b0, 1'b0);
      check_val("centre_novalid_pvout", int'(pixel_valid_out), 0);

      // Mid-frame update is held until the next frame start.
      set_params(100, 240, 64, 1'b1, 1'b0);
      probe("midframe_old_x", 384, 240, 1'b1, 1'b1);
      probe("midframe_new_x", 164, 240, 1'b1, 1'b0);
      set_params(0, 0, 0, 1'b0, 1'b1);
      probe("nextframe_new_x", 164, 240, 1'b1, 1'b1);
      probe("nextframe_old_x", 384, 240, 1'b1, 1'b0);

      // Simultaneous update and frame start apply at once.
      set_params(500, 300, 10, 1'b1, 1'b1);
      check_val("pending_simul", int'(dut.u_dbuf.pending_q), 0);
      probe("simul_510", 510, 300, 1'b1, 1'b1);
      probe("simul_511", 511, 300, 1'b1, 1'b0);

      // Small radius: always a filled disc.
      set_params(700, 500, 3, 1'b1, 1'b1);
      probe("r3_centre", 700, 500, 1'b1, 1'b1);
      probe("r3_edge", 703, 500, 1'b1, 1'b1);
      probe("r3_out", 703, 501, 1'b1, 1'b0);

      // Asynchronous reset with hits in flight.
      hcount_in = H_W'(700); vcount_in = V_W'(500); pixel_valid_in = 1'b1;
      for (int i = 0; i < LATENCY; i++) tick("prefill");
      check_val("pre_rst_hit", int'(hit_out), 1);
      #2;
      rst_n_in = 1'b0;
      #1;
      check_val("async_rst_hit", int'(hit_out), 0);
      check_val("async_rst_pv", int'(pixel_valid_out), 0);
      check_val("async_rst_red", int'(red_out), 0);
      model_clear();
      pixel_valid_in = 1'b0;
      tick("in_reset");
      rst_n_in = 1'b1;
      set_params(0, 0, 0, 1'b0, 1'b1);
      probe("post_rst_origin", 0, 0, 1'b1, 1'b1);
      probe("post_rst_10", 1, 0, 1'b1, 1'b0);
      probe("post_rst_01", 0, 1, 1'b1, 1'b0);

      // Randomized traffic around the active centre with random parameter swaps.
      for (int n = 0; n < 3000; n++) begin
         int h, v;
         if ($urandom_range(0, 19) == 0) begin
            update_in = 1'b1;
            x_in      = H_W'($urandom_range(0, 2047));
            y_in      = V_W'($urandom_range(0, 1023));
            radius_in = R_W'($urandom_range(0, 255));
         end
         new_frame_in = ($urandom_range(0, 59) == 0);
         h = m_ax + int'($urandom_range(0, 600)) - 300;
         v = m_ay + int'($urandom_range(0, 600)) - 300;
         if (h < 0) h = 0;
         if (h > 2047) h = 2047;
         if (v < 0) v = 0;
         if (v > 1023) v = 1023;
         hcount_in      = H_W'(h);
         vcount_in      = V_W'(v);
         pixel_valid_in = ($urandom_range(0, 9) != 0);
         tick("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/disc_sprite_pipe.md
# disc_sprite_pipe

Parametrised, fully pipelined successor to the fixed-radius circle sprite. It draws a filled disc, or an outline ring when the outline feature is compiled in. Radius and centre are runtime inputs, double-buffered, and applied only at frame boundaries so a moving sprite never tears. The block sits in the pixel pipeline between the hcount/vcount generator and the compositor/blender, and presents colour, a hit flag and a matching valid strobe at a fixed latency.

## Interface
- H_W, 11, hcount/x width
- V_W, 10, vcount/y width
- R_W, 8, radius width
- COLOR, 24'hFF_FF_FF, RGB888 colour in the order {R,G,B}
- RING_W, 4, ring thickness in pixels (used only with outline enabled)
- clk_in  input  1  pixel clock
- rst_n_in  input  1  asynchronous active-low reset
- hcount_in  input  H_W  current pixel column
- vcount_in  input  V_W  current pixel row
- pixel_valid_in  input  1  hcount/vcount qualify a pixel this cycle
- new_frame_in  input  1  single-cycle pulse at frame start
- x_in  input  H_W  requested centre column
- y_in  input  V_W  requested centre row
- radius_in  input  R_W  requested radius
- update_in  input  1  single-cycle pulse that latches x_in/y_in/radius_in into shadow registers
- red_out, green_out, blue_out  output  8 each  pixel colour, 0 when no hit
- hit_out  output  1  pixel lies inside the shape
- pixel_valid_out  output  1  pixel_valid_in delayed to align with the outputs

## Operation
- Shadow set: on update_in, capture x_in, y_in and radius_in, and set pending=1. A later update_in before the next frame start overwrites the shadow set.
- Active set: on new_frame_in with pending=1, copy shadow to active, register r_sq = radius², and clear pending.
- new_frame_in and update_in in the same cycle: the new inputs go directly to active and pending stays 0.
- Active values never change mid-frame.
- S1: register |hcount−x| (H_W bits), |vcount−y| (V_W bits), and the valid bit. Use unsigned compare-then-subtract; no wrap.
- S2: register dx² (2·H_W bits) and dy² (2·V_W bits).
- S3: register d² = dx²+dy² (2·H_W+1 bits, no overflow), hit = (d² ≤ r_sq) & valid, and pixel_valid_out.
- Colour is combinational from the registered hit: COLOR bytes when hit, else 0.
- radius=0: only the exact centre pixel hits.
- Pixels with pixel_valid_in=0 never hit.

## Timing
- Latency is 3 cycles from hcount/vcount/pixel_valid_in to all outputs. Throughput is one pixel per cycle with no stalls.
- Active parameters take effect for pixels sampled in the cycle after the new_frame_in edge.
- Reset (asynchronous, at any time) forces:
  - all outputs and pipeline valid bits to 0
  - active x/y/radius/r_sq and shadow set to 0
  - pending to 0
- After rst_n_in deasserts, outputs are valid starting 3 cycles after the first pixel_valid_in.

## Configuration
- DISC_SPRITE_OUTLINE_EN defined:
  - precompute inner_sq = (radius−RING_W)² at active load
  - hit = inner_sq < d² ≤ r_sq
  - if radius ≤ RING_W, inner_sq is forced such that the shape is a filled disc
- Undefined: filled disc only. RING_W is ignored and no inner-square logic is generated.

## Structure
- Shared package disc_sprite_pkg holds:
  - the pipeline depth constant (LATENCY=3)
  - the RGB888 struct typedef
  - the helper function for the squared-width calculation
- One sub-module, sprite_param_dbuf: shadow/active registers, pending flag, r_sq/inner_sq precompute. The datapath stages stay in the top module.

## Test plan
- Reset mid-frame: assert rst_n_in low while hits are in flight → all outputs 0 immediately; the next frame renders with radius 0, hitting only pixel (0,0).
- Centre (320,240), r=64, new_frame pulsed:
  - (384,240) → hit with COLOR at cycle+3
  - (385,240) → no hit
  - (365,285) → hit (d²=4050 ≤ 4096)
- Mid-frame update_in to x=100 → the current frame keeps x=320; the next frame hits at (100,240).
- Simultaneous update_in and new_frame_in with r=10 → the same frame uses r=10, and pending reads 0.
- pixel_valid_in=0 at the centre pixel → hit_out=0 and pixel_valid_out=0 after 3 cycles.
- With DISC_SPRITE_OUTLINE_EN, r=64, RING_W=4:
  - (320+62,240) → hit
  - (320+59,240) → no hit
  - r=3 → filled disc
